// File: rtl/aemb_fsl_fifo.sv
//==============================================================================
// Module   : aemb_fsl_fifo
// Brief    : FSL slave buffer for one aeMB channel. PUT words go into a TX FIFO
//            for a valid/ready consumer. GET words come from an RX FIFO filled
//            by a valid/ready producer. Define AEMB_FSL_NONBLOCK_EN to make
//            channel requests non-stalling, with a sticky error flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module aemb_fsl_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int CHAN       = 0
)(
   input  logic        sys_clk_i,
   input  logic        sys_rst_i,
   // core side
   input  logic        fsl_stb_o,
   input  logic        fsl_wre_o,
   input  logic [4:0]  fsl_adr_o,
   input  logic [31:0] fsl_dat_o,
   output logic [31:0] fsl_dat_i,
   output logic        fsl_ack_i,
   // far side, TX
   output logic [31:0] tx_dat_o,
   output logic        tx_vld_o,
   input  logic        tx_rdy_i,
   // far side, RX
   input  logic [31:0] rx_dat_i,
   input  logic        rx_vld_i,
   output logic        rx_rdy_o,
   output logic        fsl_err_o
);

   localparam int                  c_DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] c_FULL    = (DEPTH_LOG2+1)'(c_DEPTH);
   localparam logic [DEPTH_LOG2:0] c_CNT_ONE = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);
   localparam logic [4:0]          c_CHAN    = 5'(CHAN);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_t;

   state_t                r_state;
   logic                  r_ack;
   logic [31:0]           r_dat;

   logic [31:0]           r_tx_mem [c_DEPTH];
   logic [DEPTH_LOG2-1:0] r_tx_wptr;
   logic [DEPTH_LOG2-1:0] r_tx_rptr;
   logic [DEPTH_LOG2:0]   r_tx_cnt;

   logic [31:0]           r_rx_mem [c_DEPTH];
   logic [DEPTH_LOG2-1:0] r_rx_wptr;
   logic [DEPTH_LOG2-1:0] r_rx_rptr;
   logic [DEPTH_LOG2:0]   r_rx_cnt;

   logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic w_idle, w_hit, w_put, w_get;
   logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_serve;

   assign w_tx_full  = (r_tx_cnt == c_FULL);
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == c_FULL);
   assign w_rx_empty = (r_rx_cnt == '0);

   assign w_idle = (r_state == ST_IDLE) && fsl_stb_o;
   assign w_hit  = (fsl_adr_o == c_CHAN);
   assign w_put  = w_idle && w_hit &&  fsl_wre_o;
   assign w_get  = w_idle && w_hit && !fsl_wre_o;

   assign w_tx_push = w_put && !w_tx_full;
   assign w_rx_pop  = w_get && !w_rx_empty;
   assign w_tx_pop  = !w_tx_empty && tx_rdy_i;
   assign w_rx_push = rx_vld_i && !w_rx_full;

`ifdef AEMB_FSL_NONBLOCK_EN
   assign w_serve = w_idle;
`else
   // Channel requests wait for their FIFO; foreign channels complete at once.
   assign w_serve = w_idle && (!w_hit || (fsl_wre_o ? !w_tx_full : !w_rx_empty));
`endif

   assign fsl_ack_i = r_ack;
   assign fsl_dat_i = r_dat;
   assign tx_dat_o  = r_tx_mem[r_tx_rptr];
   assign tx_vld_o  = !w_tx_empty;
   assign rx_rdy_o  = !w_rx_full;

`ifdef AEMB_FSL_NONBLOCK_EN
   logic r_err;
   assign fsl_err_o = r_err;
`else
   assign fsl_err_o = 1'b0;
`endif

   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         r_state <= ST_IDLE;
         r_ack   <= 1'b0;
         r_dat   <= 32'h0;
`ifdef AEMB_FSL_NONBLOCK_EN
         r_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_serve) begin
                  r_state <= ST_ACK;
                  r_ack   <= 1'b1;
                  if (!fsl_wre_o)
                     r_dat <= w_rx_pop ? r_rx_mem[r_rx_rptr] : 32'h0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ack   <= 1'b0;
            end
         endcase
`ifdef AEMB_FSL_NONBLOCK_EN
         if ((w_put && w_tx_full) || (w_get && w_rx_empty))
            r_err <= 1'b1;
`endif
      end
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         r_tx_wptr <= '0;
         r_tx_rptr <= '0;
         r_tx_cnt  <= '0;
      end else begin
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_PTR_ONE;
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_PTR_ONE;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
            2'b01:   r_tx_cnt <= r_tx_cnt - c_CNT_ONE;
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         r_rx_wptr <= '0;
         r_rx_rptr <= '0;
         r_rx_cnt  <= '0;
      end else begin
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_PTR_ONE;
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_PTR_ONE;
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
            2'b01:   r_rx_cnt <= r_rx_cnt - c_CNT_ONE;
            default: r_rx_cnt <= r_rx_cnt;
         endcase
      end
   end

   // Storage arrays carry no reset; contents are only observed once written.
   always_ff @(posedge sys_clk_i) begin
      if (w_tx_push) r_tx_mem[r_tx_wptr] <= fsl_dat_o;
      if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_dat_i;
   end

endmodule

`default_nettype wire

// File: tb/tb_aemb_fsl_fifo.sv
//==============================================================================
// Module   : tb_aemb_fsl_fifo
// Brief    : Self-checking bench for aemb_fsl_fifo (vector table + sequences).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_aemb_fsl_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stb = 1'b0, wre = 1'b0;
   logic [4:0]  adr = '0;
   logic [31:0] wdat = '0;
   logic [31:0] rdat;
   logic        ack;
   logic [31:0] tx_dat;
   logic        tx_vld;
   logic        tx_rdy = 1'b0;
   logic [31:0] rx_dat = '0;
   logic        rx_vld = 1'b0;
   logic        rx_rdy;
   logic        err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   aemb_fsl_fifo #(.DEPTH_LOG2(4), .CHAN(0)) dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst_n),
      .fsl_stb_o (stb),
      .fsl_wre_o (wre),
      .fsl_adr_o (adr),
      .fsl_dat_o (wdat),
      .fsl_dat_i (rdat),
      .fsl_ack_i (ack),
      .tx_dat_o  (tx_dat),
      .tx_vld_o  (tx_vld),
      .tx_rdy_i  (tx_rdy),
      .rx_dat_i  (rx_dat),
      .rx_vld_i  (rx_vld),
      .rx_rdy_o  (rx_rdy),
      .fsl_err_o (err)
   );

   typedef struct {
      logic        wre;
      logic [4:0]  adr;
      logic [31:0] wdat;
      logic [31:0] exp_dat;
      logic        exp_vld;
      logic [31:0] exp_txd;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request at a negedge; returns cycles until ack, then drops stb
   // and checks that ack is a single-cycle pulse.
   task automatic req(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input int max_wait, output int cyc);
      stb = 1'b1; wre = w; adr = a; wdat = d;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!ack && cyc < max_wait);
      if (!ack) chk("ack_timeout", 32'(ack), 32'd1);
      stb = 1'b0;
      @(negedge clk);
      chk("ack_pulse", 32'(ack), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      vecs[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 32'h0,        1'b1, 32'hDEADBEEF};
      vecs[1] = '{1'b1, 5'd3,  32'h11111111, 32'h0,        1'b1, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 5'd5,  32'h0,        32'h0,        1'b1, 32'hDEADBEEF};
      vecs[3] = '{1'b0, 5'd0,  32'h0,        32'hA0A0A0A0, 1'b1, 32'hDEADBEEF};
      vecs[4] = '{1'b0, 5'd7,  32'h0,        32'h0,        1'b1, 32'hDEADBEEF};
      vecs[5] = '{1'b1, 5'd0,  32'hCAFEF00D, 32'h0,        1'b1, 32'hDEADBEEF};
      vecs[6] = '{1'b0, 5'd0,  32'h0,        32'hB1B1B1B1, 1'b1, 32'hDEADBEEF};
      vecs[7] = '{1'b0, 5'd31, 32'h0,        32'h0,        1'b1, 32'hDEADBEEF};

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_dat", rdat, 32'h0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_txvld", 32'(tx_vld), 32'd0);
      chk("rst_rxrdy", 32'(rx_rdy), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // preload RX with two words from the far side
      rx_vld = 1'b1; rx_dat = 32'hA0A0A0A0;
      @(negedge clk);
      rx_dat = 32'hB1B1B1B1;
      @(negedge clk);
      rx_vld = 1'b0;

      for (int i = 0; i < 8; i++) begin
         req(vecs[i].wre, vecs[i].adr, vecs[i].wdat, 4, cyc);
         chk($sformatf("vec%0d_lat", i), 32'(cyc), 32'd1);
         chk($sformatf("vec%0d_dat", i), rdat, vecs[i].exp_dat);
         chk($sformatf("vec%0d_txvld", i), 32'(tx_vld), 32'(vecs[i].exp_vld));
         chk($sformatf("vec%0d_txdat", i), tx_dat, vecs[i].exp_txd);
      end

      // drain the two TX words
      tx_rdy = 1'b1;
      @(negedge clk);
      chk("drain_txdat", tx_dat, 32'hCAFEF00D);
      @(negedge clk);
      tx_rdy = 1'b0;
      chk("drain_txvld", 32'(tx_vld), 32'd0);

`ifndef AEMB_FSL_NONBLOCK_EN
      // 17 PUTs into a 16-deep TX: the last one stalls until a pop
      do_reset();
      for (int i = 0; i < 16; i++) begin
         req(1'b1, 5'd0, 32'h100 + 32'(i), 4, cyc);
         chk($sformatf("fill_lat%0d", i), 32'(cyc), 32'd1);
      end
      stb = 1'b1; wre = 1'b1; adr = 5'd0; wdat = 32'h110;
      repeat (4) @(negedge clk);
      chk("stall_ack", 32'(ack), 32'd0);
      tx_rdy = 1'b1;
      @(negedge clk);
      tx_rdy = 1'b0;
      chk("stall_ack_pop", 32'(ack), 32'd0);
      chk("stall_head2", tx_dat, 32'h101);
      @(negedge clk);
      chk("stall_release", 32'(ack), 32'd1);
      stb = 1'b0;
      @(negedge clk);
      tx_rdy = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         chk($sformatf("order%0d", i), tx_dat, 32'h100 + 32'(i));
         @(negedge clk);
      end
      tx_rdy = 1'b0;
      chk("order_empty", 32'(tx_vld), 32'd0);

      // GET waits on empty RX, completes one cycle after the push lands
      stb = 1'b1; wre = 1'b0; adr = 5'd0;
      repeat (3) @(negedge clk);
      chk("get_wait", 32'(ack), 32'd0);
      rx_vld = 1'b1; rx_dat = 32'h12345678;
      @(negedge clk);
      rx_vld = 1'b0;
      chk("get_push_ack", 32'(ack), 32'd0);
      @(negedge clk);
      chk("get_ack", 32'(ack), 32'd1);
      chk("get_dat", rdat, 32'h12345678);
      stb = 1'b0;
      @(negedge clk);

      // reset while a PUT is stalled on a full TX
      for (int i = 0; i < 16; i++) req(1'b1, 5'd0, 32'h200 + 32'(i), 4, cyc);
      stb = 1'b1; wre = 1'b1; adr = 5'd0; wdat = 32'hABCD0017;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(ack), 32'd0);
      chk("mid_rst_txvld", 32'(tx_vld), 32'd0);
      chk("mid_rst_rxrdy", 32'(rx_rdy), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ack", 32'(ack), 32'd1);
      chk("post_rst_txdat", tx_dat, 32'hABCD0017);
      stb = 1'b0;
      @(negedge clk);
      chk("blk_err", 32'(err), 32'd0);
`else
      // non-blocking: GET on empty RX completes with zero and flags error
      do_reset();
      req(1'b0, 5'd0, 32'h0, 4, cyc);
      chk("nb_get_lat", 32'(cyc), 32'd1);
      chk("nb_get_dat", rdat, 32'h0);
      chk("nb_get_err", 32'(err), 32'd1);
      req(1'b1, 5'd0, 32'h55AA55AA, 4, cyc);
      chk("nb_err_sticky", 32'(err), 32'd1);
      do_reset();
      chk("nb_err_clr", 32'(err), 32'd0);
      for (int i = 0; i < 17; i++) req(1'b1, 5'd0, 32'h300 + 32'(i), 4, cyc);
      chk("nb_put_lat", 32'(cyc), 32'd1);
      chk("nb_put_err", 32'(err), 32'd1);
      chk("nb_put_head", tx_dat, 32'h300);
`endif

      // fill and drain both FIFOs three times across pointer wrap
      do_reset();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 16; i++) req(1'b1, 5'd0, 32'h1000 * 32'(r + 1) + 32'(i), 4, cyc);
         chk($sformatf("r%0d_txfull", r), 32'(tx_vld), 32'd1);
         tx_rdy = 1'b1;
         for (int i = 0; i < 16; i++) begin
            chk($sformatf("r%0d_tx%0d", r, i), tx_dat, 32'h1000 * 32'(r + 1) + 32'(i));
            @(negedge clk);
         end
         tx_rdy = 1'b0;
         chk($sformatf("r%0d_txempty", r), 32'(tx_vld), 32'd0);

         rx_vld = 1'b1;
         for (int i = 0; i < 16; i++) begin
            rx_dat = 32'h8000 * 32'(r + 1) + 32'(i);
            @(negedge clk);
         end
         rx_dat = 32'hBAD00000;
         @(negedge clk);
         rx_vld = 1'b0;
         chk($sformatf("r%0d_rxfull", r), 32'(rx_rdy), 32'd0);
         for (int i = 0; i < 16; i++) begin
            req(1'b0, 5'd0, 32'h0, 4, cyc);
            chk($sformatf("r%0d_rx%0d", r, i), rdat, 32'h8000 * 32'(r + 1) + 32'(i));
         end
         chk($sformatf("r%0d_rxrdy", r), 32'(rx_rdy), 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
